load_reg_bank: RTL and testbench

Parametrised multi-channel load register bank for the game datapath: holds one WIDTH-bit value per player channel. Each channel is loaded through a valid/ready write port and cleared individually or all at once. Every accepted load produces a one-entry event toward downstream game logic. Per-channel "loaded" flags and an all-loaded flag let the turn controller know when every player has committed.

---
 rtl/load_reg_bank_pkg.sv | 14 +
 rtl/load_reg_evt_slot.sv | 35 +++
 rtl/load_reg_bank.sv | 125 ++++++++++++
 tb/tb_load_reg_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_reg_bank_pkg.sv
// Shared types and default sizing for the player load register bank.
package load_reg_bank_pkg;

    localparam int unsigned LRB_WIDTH  = 4;
    localparam int unsigned LRB_NUM_CH = 4;
    localparam int unsigned LRB_CH_W   = 2;

    // Load event record at the default sizing.
    typedef struct packed {
        logic [LRB_CH_W-1:0]  ch;
        logic [LRB_WIDTH-1:0] data;
    } lrb_evt_t;

endpackage

// File: rtl/load_reg_evt_slot.sv
// Single-entry valid/ready event register; o_space means a new entry can be taken this cycle.
module load_reg_evt_slot #(
    parameter int unsigned EW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [EW-1:0] i_entry,
    input  logic          i_pop_ready,
    output logic          o_valid,
    output logic [EW-1:0] o_entry,
    output logic          o_space
);

    logic          r_valid;
    logic [EW-1:0] r_entry;

    assign o_space = !r_valid || i_pop_ready;
    assign o_valid = r_valid;
    assign o_entry = r_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_push) begin
            // A push in the same cycle as a pop replaces the entry.
            r_valid <= 1'b1;
            r_entry <= i_entry;
        end else if (r_valid && i_pop_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/load_reg_bank.sv
// Multi-channel load register bank with per-channel loaded flags and a load event slot.
// Optional LOAD_REG_BANK_LOCK_EN: loaded channels reject overwrites and pulse wr_err.
module load_reg_bank
    import load_reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH  = LRB_WIDTH,
    parameter int unsigned NUM_CH = LRB_NUM_CH,
    parameter int unsigned CH_W   = LRB_CH_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    clr_en,
    input  logic [CH_W-1:0]         clr_ch,
    input  logic                    clr_all,
    output logic [NUM_CH*WIDTH-1:0] data_flat,
    output logic [NUM_CH-1:0]       loaded,
    output logic                    all_loaded,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [CH_W-1:0]         evt_ch,
    output logic [WIDTH-1:0]        evt_data,
    output logic                    wr_err
);

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] data;
    } evt_rec_t;

    localparam int unsigned   EVT_W    = $bits(evt_rec_t);
    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic [WIDTH-1:0]  r_data [NUM_CH];
    logic [NUM_CH-1:0] r_loaded;

    logic     w_space;
    logic     w_accept;
    logic     w_ch_ok;
    logic     w_locked;
    logic     w_load;
    evt_rec_t w_push_rec;
    evt_rec_t w_evt_rec;

    assign wr_ready = w_space && !clr_all && !(clr_en && (clr_ch == wr_ch)) && !rst;
    assign w_accept = wr_valid && wr_ready;
    assign w_ch_ok  = {1'b0, wr_ch} < NUM_CH_V;

`ifdef LOAD_REG_BANK_LOCK_EN
    logic [(2**CH_W)-1:0] w_loaded_ext;
    logic                 r_wr_err;

    // Pad so any wr_ch value indexes safely; out-of-range channels read as unlocked.
    always_comb begin
        w_loaded_ext             = '0;
        w_loaded_ext[NUM_CH-1:0] = r_loaded;
    end

    assign w_locked = w_loaded_ext[wr_ch];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_accept && w_ch_ok && w_locked;
        end
    end

    assign wr_err = r_wr_err;
`else
    assign w_locked = 1'b0;
    assign wr_err   = 1'b0;
`endif

    assign w_load = w_accept && w_ch_ok && !w_locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_data[c] <= '0;
            end
            r_loaded <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clr_all || (clr_en && (clr_ch == CH_W'(c)))) begin
                    r_data[c]   <= '0;
                    r_loaded[c] <= 1'b0;
                end else if (w_load && (wr_ch == CH_W'(c))) begin
                    r_data[c]   <= wr_data;
                    r_loaded[c] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign data_flat[g*WIDTH +: WIDTH] = r_data[g];
    end

    assign loaded     = r_loaded;
    assign all_loaded = &r_loaded;

    assign w_push_rec.ch   = wr_ch;
    assign w_push_rec.data = wr_data;

    load_reg_evt_slot #(
        .EW (EVT_W)
    ) u_evt_slot (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_load),
        .i_entry     (w_push_rec),
        .i_pop_ready (evt_ready),
        .o_valid     (evt_valid),
        .o_entry     (w_evt_rec),
        .o_space     (w_space)
    );

    assign evt_ch   = w_evt_rec.ch;
    assign evt_data = w_evt_rec.data;

endmodule

// File: tb/tb_load_reg_bank.sv
// Randomized scoreboard bench for load_reg_bank against a behavioural channel model.
module tb_load_reg_bank;
    import load_reg_bank_pkg::*;

    localparam int W  = LRB_WIDTH;
    localparam int N  = LRB_NUM_CH;
    localparam int CW = LRB_CH_W;
    localparam bit LockMode =
`ifdef LOAD_REG_BANK_LOCK_EN
        1'b1;
`else
        1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            wr_valid;
    logic            wr_ready;
    logic [CW-1:0]   wr_ch;
    logic [W-1:0]    wr_data;
    logic            clr_en;
    logic [CW-1:0]   clr_ch;
    logic            clr_all;
    logic [N*W-1:0]  data_flat;
    logic [N-1:0]    loaded;
    logic            all_loaded;
    logic            evt_valid;
    logic            evt_ready;
    logic [CW-1:0]   evt_ch;
    logic [W-1:0]    evt_data;
    logic            wr_err;

    load_reg_bank dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .clr_en     (clr_en),
        .clr_ch     (clr_ch),
        .clr_all    (clr_all),
        .data_flat  (data_flat),
        .loaded     (loaded),
        .all_loaded (all_loaded),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_ch     (evt_ch),
        .evt_data   (evt_data),
        .wr_err     (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int       m_val [N];
    bit       m_ld  [N];
    bit       m_evt_valid;
    bit       m_err;
    lrb_evt_t exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (!m_evt_valid || evt_ready) && !clr_all && !(clr_en && (clr_ch == wr_ch)) && !rst;
    endfunction

    task automatic check_outputs();
        int exp_flat;
        int exp_loaded;
        bit exp_all;
        exp_flat   = 0;
        exp_loaded = 0;
        exp_all    = 1'b1;
        for (int c = 0; c < N; c++) begin
            exp_flat   = exp_flat | (m_val[c] << (c * W));
            exp_loaded = exp_loaded | (int'(m_ld[c]) << c);
            exp_all    = exp_all & m_ld[c];
        end
        chk("wr_ready", int'(wr_ready), int'(model_ready()));
        chk("data_flat", int'(data_flat), exp_flat);
        chk("loaded", int'(loaded), exp_loaded);
        chk("all_loaded", int'(all_loaded), int'(exp_all));
        chk("evt_valid", int'(evt_valid), int'(m_evt_valid));
        chk("wr_err", int'(wr_err), int'(m_err));
    endtask

    // Applies the inputs present at this edge to the model.
    task automatic model_step();
        bit       acc;
        bit       nvalid;
        bit       nerr;
        int       ch;
        lrb_evt_t rec;
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                m_val[c] = 0;
                m_ld[c]  = 1'b0;
            end
            m_evt_valid = 1'b0;
            m_err       = 1'b0;
            exp_q.delete();
            return;
        end
        acc    = wr_valid && model_ready();
        nvalid = m_evt_valid && !evt_ready;
        nerr   = 1'b0;
        ch     = int'(wr_ch);
        if (acc && ch < N) begin
            if (LockMode && m_ld[ch]) begin
                nerr = 1'b1;
            end else begin
                m_val[ch] = int'(wr_data);
                m_ld[ch]  = 1'b1;
                rec.ch    = wr_ch;
                rec.data  = wr_data;
                exp_q.push_back(rec);
                nvalid = 1'b1;
            end
        end
        if (clr_all) begin
            for (int c = 0; c < N; c++) begin
                m_val[c] = 0;
                m_ld[c]  = 1'b0;
            end
        end else if (clr_en && int'(clr_ch) < N) begin
            m_val[int'(clr_ch)] = 0;
            m_ld[int'(clr_ch)]  = 1'b0;
        end
        m_evt_valid = nvalid;
        m_err       = nerr;
    endtask

    task automatic cyc(input bit r, input bit wv, input int wc, input int wd,
                       input bit ce, input int cc, input bit ca, input bit er);
        rst       = r;
        wr_valid  = wv;
        wr_ch     = CW'(wc);
        wr_data   = W'(wd);
        clr_en    = ce;
        clr_ch    = CW'(cc);
        clr_all   = ca;
        evt_ready = er;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Event monitor: compare the entry that will be consumed at the coming edge.
    always @(negedge clk) begin
        lrb_evt_t e;
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL evt_pop: got unexpected event ch %0d data 0x%0h, expected none",
                         evt_ch, evt_data);
            end else begin
                e = exp_q.pop_front();
                chk("evt_ch", int'(evt_ch), int'(e.ch));
                chk("evt_data", int'(evt_data), int'(e.data));
            end
        end
    end

    initial begin
        for (int c = 0; c < N; c++) begin
            m_val[c] = 0;
            m_ld[c]  = 1'b0;
        end
        m_evt_valid = 1'b0;
        m_err       = 1'b0;
        rst = 1'b1; wr_valid = 1'b0; wr_ch = '0; wr_data = '0;
        clr_en = 1'b0; clr_ch = '0; clr_all = 1'b0; evt_ready = 1'b0;
        @(posedge clk);
        model_step();
        #1;
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        // Idle after reset, then a single load to ch2
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 2, 'hA, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Backpressure: second write stalls until evt_ready rises
        cyc(0, 1, 0, 'h3, 0, 0, 0, 1);
        cyc(0, 1, 1, 'h5, 0, 0, 0, 0);
        cyc(0, 1, 1, 'h5, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        // Fill every channel, then clear ch1
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        for (int c = 0; c < N; c++) cyc(0, 1, c, c + 7, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        // Same-cycle clear and write on ch3
        cyc(0, 1, 3, 'hF, 1, 3, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        // Overwrite of a loaded channel, then clear and rewrite
        cyc(0, 1, 1, 'h6, 0, 0, 0, 1);
        cyc(0, 1, 1, 'h9, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1, 0, 1);
        cyc(0, 1, 1, 'h9, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        // Write on one channel alongside a clear on another
        cyc(0, 1, 0, 'hC, 1, 2, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, N - 1)), int'($urandom_range(0, (1 << W) - 1)),
                ($urandom_range(0, 7) == 0), int'($urandom_range(0, N - 1)),
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1));
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("evt_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
